// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - fetch-to-decode decoupling FIFO with flush and fetch back-pressure
module if_id_fetch_queue #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [BIT_NUMBER-1:0]   if_pc,
  input  logic [BIT_NUMBER-1:0]   if_instruction,
  output logic                    if_freeze,
  input  logic                    id_freeze,
  input  logic                    flush,
  output logic                    id_valid,
  output logic [BIT_NUMBER-1:0]   id_pc,
  output logic [BIT_NUMBER-1:0]   id_instruction,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [BIT_NUMBER-1:0] pc_mem    [DEPTH];
  logic [BIT_NUMBER-1:0] instr_mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  push;
  logic                  pop;

  // Outputs depend only on registered state, so flush/id_freeze never reach id_* combinationally.
  assign if_freeze      = (count == FULL_COUNT);
  assign id_valid       = (count != '0);
  assign id_pc          = id_valid ? pc_mem[rd_ptr]    : '0;
  assign id_instruction = id_valid ? instr_mem[rd_ptr] : '0;

  // A full queue refuses pushes even when the same edge pops.
  assign push = if_valid & ~if_freeze & ~flush;
  assign pop  = id_valid & ~id_freeze & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= if_pc;
        instr_mem[wr_ptr] <= if_instruction;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - scoreboard bench for if_id_fetch_queue at DEPTH 2 and 4
module tb_if_id_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D  = (g == 0) ? 2 : 4;
    localparam int CW = $clog2(D) + 1;

    logic          if_valid, id_freeze, flush, if_freeze, id_valid;
    logic [31:0]   if_pc, if_instruction, id_pc, id_instruction;
    logic [CW-1:0] count;
    logic [63:0]   mq[$];
    logic [31:0]   obs_pc[$];
    logic [63:0]   eh;
    bit            pu, po;

    if_id_fetch_queue #(.BIT_NUMBER(32), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
      .if_instruction(if_instruction), .if_freeze(if_freeze), .id_freeze(id_freeze),
      .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
      .id_instruction(id_instruction), .count(count)
    );

    // Reference queue: accepted fetch words enter at the back, decode consumes the front.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        mq.delete();
      end else begin
        po = (mq.size() != 0) && !id_freeze && !flush;
        pu = if_valid && (mq.size() < D) && !flush;
        if (flush) begin
          mq.delete();
        end else begin
          if (po) void'(mq.pop_front());
          if (pu) mq.push_back({if_pc, if_instruction});
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        eh = (mq.size() != 0) ? mq[0] : 64'd0;
        chk($sformatf("mon%0d_count", D), 32'(count), mq.size());
        chk($sformatf("mon%0d_if_freeze", D), 32'(if_freeze), 32'(mq.size() == D));
        chk($sformatf("mon%0d_id_valid", D), 32'(id_valid), 32'(mq.size() != 0));
        chk($sformatf("mon%0d_id_pc", D), id_pc, eh[63:32]);
        chk($sformatf("mon%0d_id_instr", D), id_instruction, eh[31:0]);
        if (id_valid && !id_freeze && !flush) obs_pc.push_back(id_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic frz, input logic fl);
    u[0].if_valid = v; u[0].if_pc = pc; u[0].if_instruction = ins;
    u[0].id_freeze = frz; u[0].flush = fl;
  endtask

  task automatic idle1();
    u[1].if_valid = 1'b0; u[1].if_pc = '0; u[1].if_instruction = '0;
    u[1].id_freeze = 1'b0; u[1].flush = 1'b0;
  endtask

  task automatic chk_empty0(input string nm);
    chk({nm, "_count"}, 32'(u[0].count), 0);
    chk({nm, "_valid"}, 32'(u[0].id_valid), 0);
    chk({nm, "_freeze"}, 32'(u[0].if_freeze), 0);
    chk({nm, "_pc"}, u[0].id_pc, 0);
    chk({nm, "_instr"}, u[0].id_instruction, 0);
  endtask

  int  s0, s1, n0, n1, cyc;
  bit  a0, a1;

  initial begin
    rst = 1'b0;
    drive0(0, 0, 0, 0, 0);
    idle1();
    repeat (2) @(posedge clk);
    #1;
    chk_empty0("reset");
    rst = 1'b1;

    // fill under stall, drop when full, then drain
    drive0(1, 32'd4, 32'hE3A01001, 1, 0); tick();
    drive0(1, 32'd8, 32'hE2811002, 1, 0); tick();
    chk("fill_count", 32'(u[0].count), 2);
    chk("fill_freeze", 32'(u[0].if_freeze), 1);
    chk("fill_head", u[0].id_pc, 4);
    drive0(1, 32'd12, 32'hE0800001, 1, 0); tick();
    chk("drop_count", 32'(u[0].count), 2);
    chk("drop_head", u[0].id_pc, 4);
    chk("drop_head_instr", u[0].id_instruction, 32'hE3A01001);
    drive0(0, 0, 0, 0, 0); tick();
    chk("drain_pc8", u[0].id_pc, 8);
    chk("drain_instr8", u[0].id_instruction, 32'hE2811002);
    tick();
    chk_empty0("drain");

    // simultaneous push and pop
    drive0(1, 32'd4, 32'h11111111, 0, 0); tick();
    chk("simul_pre_count", 32'(u[0].count), 1);
    drive0(1, 32'd8, 32'h22222222, 0, 0); tick();
    chk("simul_count", 32'(u[0].count), 1);
    chk("simul_head", u[0].id_pc, 8);
    drive0(0, 0, 0, 0, 0); tick();
    chk_empty0("simul_drain");

    // flush with a concurrent fetch word
    drive0(1, 32'd4, 32'hAAAA0001, 1, 0); tick();
    drive0(1, 32'd8, 32'hAAAA0002, 1, 0); tick();
    drive0(1, 32'd12, 32'hAAAA0003, 1, 1); tick();
    chk_empty0("flush");
    drive0(1, 32'h40, 32'hBBBB0040, 1, 0); tick();
    chk("flush_next_head", u[0].id_pc, 32'h40);
    chk("flush_next_count", 32'(u[0].count), 1);
    drive0(1, 32'h44, 32'hBBBB0044, 1, 0); tick();
    chk("pre_reset_count", 32'(u[0].count), 2);

    // asynchronous reset mid-stream
    drive0(0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_empty0("async_reset");
    @(posedge clk);
    #1;
    drive0(0, 0, 0, 0, 0);
    rst = 1'b1;

    // ordered stream with random decode stalls on both depths
    s0 = u[0].obs_pc.size();
    s1 = u[1].obs_pc.size();
    n0 = 4; n1 = 4; cyc = 0;
    while ((n0 <= 40 || n1 <= 40) && cyc < 500) begin
      u[0].if_valid = (n0 <= 40) && ($urandom_range(0, 3) != 0);
      u[0].if_pc = n0; u[0].if_instruction = $urandom;
      u[0].id_freeze = 1'($urandom_range(0, 1)); u[0].flush = 1'b0;
      u[1].if_valid = (n1 <= 40) && ($urandom_range(0, 3) != 0);
      u[1].if_pc = n1; u[1].if_instruction = $urandom;
      u[1].id_freeze = 1'($urandom_range(0, 1)); u[1].flush = 1'b0;
      @(negedge clk);
      a0 = u[0].if_valid && !u[0].if_freeze;
      a1 = u[1].if_valid && !u[1].if_freeze;
      tick();
      if (a0) n0 += 4;
      if (a1) n1 += 4;
      cyc++;
    end
    chk("stream_budget", 32'(cyc < 500), 1);
    drive0(0, 0, 0, 0, 0);
    idle1();
    repeat (12) tick();
    chk("stream_done2", 32'(u[0].count), 0);
    chk("stream_done4", 32'(u[1].count), 0);
    chk("order_len2", u[0].obs_pc.size() - s0, 10);
    chk("order_len4", u[1].obs_pc.size() - s1, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("order2_%0d", k),
          (s0 + k < u[0].obs_pc.size()) ? u[0].obs_pc[s0 + k] : 32'hFFFFFFFF, 32'(4 + 4 * k));
      chk($sformatf("order4_%0d", k),
          (s1 + k < u[1].obs_pc.size()) ? u[1].obs_pc[s1 + k] : 32'hFFFFFFFF, 32'(4 + 4 * k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
